shift_counter_ctrl: RTL and testbench

- Sequencer and configurer for a WIDTH-bit shift-register counter datapath.
- A start request loads a seed and selects ring, Johnson, LFSR or hold mode; the block then steps the register a programmed number of times and signals done.
- Used to drive ring and Johnson sequences and pseudo-random patterns under control, with abort and all-zero-LFSR lockup detection.

---
 rtl/shift_counter_ctrl.sv | 132 +++++++++++++
 tb/tb_shift_counter_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_counter_ctrl.sv
// Sequencer for a WIDTH-bit ring/Johnson/LFSR/hold shift-register counter.
// Define SHIFT_COUNTER_CTRL_PAUSE_EN to add a pause input that freezes RUN.
module shift_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  input  logic             abort,
`ifdef SHIFT_COUNTER_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             stuck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RING = 2'b00;
  localparam logic [1:0] MODE_JOHN = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  state_t           state;
  state_t           next_state;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] seed_r;
  logic [CNT_W-1:0] remaining;
  logic             fb;
  logic             hold_run;
  logic             lfsr_zero;

`ifdef SHIFT_COUNTER_CTRL_PAUSE_EN
  assign hold_run = pause;
`else
  assign hold_run = 1'b0;
`endif

  assign lfsr_zero = (mode_r == MODE_LFSR) && (seed_r == '0);

  always_comb begin
    fb = 1'b0;
    case (mode_r)
      MODE_RING: fb = q[WIDTH-1];
      MODE_JOHN: fb = ~q[WIDTH-1];
      MODE_LFSR: fb = q[WIDTH-1] ^ q[0];
      default:   fb = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        if (abort)                    next_state = IDLE;
        else if (lfsr_zero)           next_state = DONE;
        else if (remaining == '0)     next_state = DONE;
        else                          next_state = RUN;
      end
      RUN: begin
        if (abort)                                    next_state = IDLE;
        else if (!hold_run && remaining == CNT_W'(1)) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Steps are captured straight into the down-counter at start; LOAD leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      mode_r    <= '0;
      seed_r    <= '0;
      remaining <= '0;
      stuck     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_r    <= mode;
            seed_r    <= seed;
            remaining <= steps;
            stuck     <= 1'b0;
          end
        end
        LOAD: begin
          if (!abort) begin
            q <= seed_r;
            if (lfsr_zero) stuck <= 1'b1;
          end
        end
        RUN: begin
          if (!abort && !hold_run) begin
            if (mode_r != MODE_HOLD) q <= {q[WIDTH-2:0], fb};
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags are registered decodes of the state, so they trail it by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state == LOAD) || (state == RUN);
      done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_shift_counter_ctrl.sv
// Randomized self-checking bench for shift_counter_ctrl against a per-run
// timeline model of the shift sequence, busy/done windows, abort and stuck.
module tb_shift_counter_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] steps;
  logic             abort;
  logic             pause;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             stuck;

  int errors = 0;
  int checks = 0;
  int model_q = 0;

  always #5 clk = ~clk;

  shift_counter_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .seed  (seed),
    .steps (steps),
    .abort (abort),
`ifdef SHIFT_COUNTER_CTRL_PAUSE_EN
    .pause (pause),
`endif
    .q     (q),
    .busy  (busy),
    .done  (done),
    .stuck (stuck)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Next register value for each mode, using plain integer arithmetic.
  function automatic int nextValue(input int m, input int v);
    int top     = (v >> (WIDTH - 1)) & 1;
    int low     = v & 1;
    int shifted = (v * 2) % (2 ** WIDTH);
    case (m)
      0:       return shifted + top;
      1:       return shifted + (1 - top);
      2:       return shifted + (top ^ low);
      default: return v;
    endcase
  endfunction

  task automatic applyStimulus(input int m, input int s, input int n, input int abort_edge,
                               input bit abort0, input int start_edge,
                               input int p_edge, input int p_len);
    int  qexp[64];
    int  cur;
    int  cnt;
    int  end_e;
    bit  aborted;
    bit  stuck_case;
    int  shifts;
    int  qv;
    stuck_case = (m == 2) && (s == 0);
    shifts     = stuck_case ? 0 : n;
    cur        = model_q;
    cnt        = 0;
    end_e      = 0;
    aborted    = 1'b0;
    qexp[0]    = model_q;
    for (int e = 1; e < 64 && end_e == 0; e++) begin
      if (e == abort_edge) begin
        aborted = 1'b1;
        end_e   = e;
      end else if (e == 1) begin
        cur = s;
        if (shifts == 0) end_e = 1;
      end else if (!(e >= p_edge && e < p_edge + p_len)) begin
        cur = nextValue(m, cur);
        cnt++;
        if (cnt == shifts) end_e = e;
      end
      qexp[e] = cur;
    end

    for (int e = 0; e <= end_e + 2; e++) begin
      @(negedge clk);
      start = (e == 0) || (e == start_edge);
      abort = (e == abort_edge) || (e == 0 && abort0);
      pause = (e >= p_edge) && (e < p_edge + p_len);
      if (e == 0) begin
        mode  = 2'(m);
        seed  = WIDTH'(s);
        steps = CNT_W'(n);
      end else begin
        mode  = 2'($urandom);
        seed  = WIDTH'($urandom);
        steps = CNT_W'($urandom);
      end
      @(posedge clk);
      #1;
      qv = qexp[(e < end_e) ? e : end_e];
      checkOutput($sformatf("q m%0d s%0h e%0d", m, s, e), 32'(q), 32'(qv));
      checkOutput($sformatf("busy e%0d", e), 32'(busy), 32'(e >= 1 && e <= end_e));
      checkOutput($sformatf("done e%0d", e), 32'(done), 32'(!aborted && e == end_e + 1));
      checkOutput($sformatf("stuck e%0d", e), 32'(stuck),
                  32'(e >= 1 && stuck_case && abort_edge != 1));
    end
    @(negedge clk);
    start   = 1'b0;
    abort   = 1'b0;
    pause   = 1'b0;
    model_q = qexp[end_e];
  endtask

  task automatic resetMidRun();
    @(negedge clk);
    start = 1'b1; mode = 2'b00; seed = 4'b0001; steps = 8'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid q", 32'(q), 32'd0);
    checkOutput("rst_mid busy", 32'(busy), 32'd0);
    checkOutput("rst_mid done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    model_q = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sm, ss, sn, ab, st, pe, pl;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
    mode = '0; seed = '0; steps = '0;
    #12;
    checkOutput("reset q", 32'(q), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset stuck", 32'(stuck), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 4'b0001, 3, 0, 1'b0, 0, 0, 0);
    checkOutput("ring final", 32'(q), 32'b1000);
    applyStimulus(1, 4'b0000, 8, 0, 1'b0, 0, 0, 0);
    applyStimulus(2, 4'b0001, 15, 0, 1'b0, 0, 0, 0);
    checkOutput("lfsr final", 32'(q), 32'b0001);
    applyStimulus(2, 4'b0000, 15, 0, 1'b0, 0, 0, 0);
    checkOutput("lfsr stuck", 32'(stuck), 32'd1);
    applyStimulus(0, 4'b0001, 10, 4, 1'b0, 3, 0, 0);
    checkOutput("abort hold", 32'(q), 32'b0100);
    applyStimulus(0, 4'b1010, 0, 0, 1'b1, 0, 0, 0);
    applyStimulus(3, 4'b0110, 4, 0, 1'b0, 0, 0, 0);
    applyStimulus(1, 4'b0011, 5, 1, 1'b0, 0, 0, 0);
`ifdef SHIFT_COUNTER_CTRL_PAUSE_EN
    applyStimulus(0, 4'b0001, 3, 0, 1'b0, 0, 3, 2);
`endif
    resetMidRun();

    for (int i = 0; i < 40; i++) begin
      sm = int'($urandom_range(0, 3));
      ss = int'($urandom_range(0, 15));
      sn = int'($urandom_range(0, 12));
      ab = 0;
      st = 0;
      pe = 0;
      pl = 0;
      if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, sn + 1));
      if ($urandom_range(0, 1) == 0) st = int'($urandom_range(1, (ab != 0) ? ab : sn + 1));
`ifdef SHIFT_COUNTER_CTRL_PAUSE_EN
      if (sn > 0) begin
        pe = int'($urandom_range(2, sn + 1));
        pl = int'($urandom_range(0, 2));
      end
`endif
      applyStimulus(sm, ss, sn, ab, 1'($urandom_range(0, 1)), st, pe, pl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
